// File: rtl/autotest_multi_ctrl.sv
// autotest_multi_ctrl: SD-driven multi-vector UUT test sequencer.
// Reads vector blocks via the SPI host, runs the UUT, writes result blocks.
module autotest_multi_ctrl #(
    parameter int          N_IN_BYTES  = 4,
    parameter int          N_OUT       = 2,
    parameter logic [31:0] TIMEOUT     = 32'h06E00000,
    parameter logic [31:0] CFG_BASE    = 32'h00100000,
    parameter logic [31:0] RES_BASE    = 32'h00200000,
    parameter logic [31:0] SIGNATURE   = 32'hAABBCCDD,
    parameter logic [15:0] MAX_VECTORS = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_busy,
    input  logic                    spi_err,
    input  logic [7:0]              spi_data_out,
    output logic [31:0]             spi_block_addr,
    output logic [7:0]              spi_data_in,
    output logic                    spi_rst,
    output logic                    spi_r_block,
    output logic                    spi_r_byte,
    output logic                    spi_w_block,
    output logic                    spi_w_byte,
    output logic                    uut_rst,
    output logic                    uut_start,
    output logic [8*N_IN_BYTES-1:0] uut_din,
    input  logic [8*N_OUT-1:0]      uut_dout,
    input  logic [N_OUT-1:0]        uut_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [15:0]             vectors_done
);

    localparam int RDN = 5 + N_IN_BYTES;
    localparam int RW = $clog2(RDN);
    localparam int HDR = 10 + N_IN_BYTES + N_OUT;
    localparam int HW = $clog2(HDR);
    localparam logic [9:0] RDN_W = 10'(RDN);
    localparam logic [9:0] HDR_W = 10'(HDR);

    typedef enum logic [4:0] {
        IDLE, SPI_RST, SPI_RST_W, RD_BLK, RD_BLK_W, RD_REQ, RD_W, CHECK,
        START, RUN, WR_BLK, WR_BLK_W, WR_REQ, WR_W, NEXT, DONE, ERROR
    } state_t;

    state_t             state, state_n;
    logic [9:0]         b;
    logic [7:0]         rd [RDN];
    logic [7:0]         j;
    logic [31:0]        timer;
    logic               tmo;
    logic [8*N_OUT-1:0] cap;
    logic [N_OUT-1:0]   got, got_n;
    logic [7:0]         hdr [HDR];
    logic [31:0]        sig;
    logic [7:0]         iter_eff;
    logic [9:0]         widx;
    logic [7:0]         wdat;
    logic               rd_st, wr_st;

    assign sig = {rd[0], rd[1], rd[2], rd[3]};
    assign iter_eff = (rd[4] == 8'h00) ? 8'd1 : rd[4];
    assign got_n = got | uut_valid;
    assign rd_st = state inside {RD_BLK, RD_BLK_W, RD_REQ, RD_W};
    assign wr_st = state inside {WR_BLK, WR_BLK_W, WR_REQ, WR_W};

    // Block byte 5 lands in the most significant stimulus byte.
    for (genvar i = 0; i < N_IN_BYTES; i++) begin : g_din
        assign uut_din[8*(N_IN_BYTES-1-i) +: 8] = rd[5+i];
    end

    always_comb begin
        for (int i = 0; i < HDR; i++) hdr[i] = 8'h00;
        for (int i = 0; i < 4; i++) hdr[i] = rd[i];
        hdr[4] = j;
        for (int i = 0; i < N_IN_BYTES; i++) hdr[5+i] = rd[5+i];
        hdr[5+N_IN_BYTES] = {6'b0, ~&got, tmo};
        hdr[6+N_IN_BYTES] = timer[31:24];
        hdr[7+N_IN_BYTES] = timer[23:16];
        hdr[8+N_IN_BYTES] = timer[15:8];
        hdr[9+N_IN_BYTES] = timer[7:0];
        for (int c = 0; c < N_OUT; c++) hdr[10+N_IN_BYTES+c] = cap[8*c +: 8];
    end

    assign widx = (state == WR_W) ? b + 10'd1 : b;
    assign wdat = (widx < HDR_W) ? hdr[widx[HW-1:0]] : 8'h00;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = SPI_RST;
            SPI_RST:   if (spi_busy) state_n = SPI_RST_W;
            SPI_RST_W: if (!spi_busy) state_n = RD_BLK;
            RD_BLK:    if (spi_busy) state_n = RD_BLK_W;
            RD_BLK_W:  if (!spi_busy) state_n = RD_REQ;
            RD_REQ:    if (spi_busy) state_n = RD_W;
            RD_W:      if (!spi_busy) state_n = (b == 10'd511) ? CHECK : RD_REQ;
            CHECK:     state_n = (sig != SIGNATURE || vectors_done == MAX_VECTORS)
                                 ? DONE : START;
            START:     state_n = RUN;
            RUN:       if (&got_n || timer == TIMEOUT - 32'd1) state_n = WR_BLK;
            WR_BLK:    if (spi_busy) state_n = WR_BLK_W;
            WR_BLK_W:  if (!spi_busy) state_n = WR_REQ;
            WR_REQ:    if (spi_busy) state_n = WR_W;
            WR_W:      if (!spi_busy) state_n = (b == 10'd511) ? NEXT : WR_REQ;
            NEXT:      state_n = ({1'b0, j} + 9'd1 < {1'b0, iter_eff}) ? START : SPI_RST;
            DONE:      state_n = DONE;
            ERROR:     state_n = ERROR;
            default:   state_n = IDLE;
        endcase
        if ((rd_st || wr_st) && spi_err) state_n = ERROR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            b              <= '0;
            for (int i = 0; i < RDN; i++) rd[i] <= 8'h00;
            j              <= '0;
            timer          <= '0;
            tmo            <= 1'b0;
            cap            <= '0;
            got            <= '0;
            spi_block_addr <= '0;
            spi_data_in    <= 8'hFF;
            spi_rst        <= 1'b0;
            spi_r_block    <= 1'b0;
            spi_r_byte     <= 1'b0;
            spi_w_block    <= 1'b0;
            spi_w_byte     <= 1'b0;
            uut_rst        <= 1'b1;
            uut_start      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= 2'd0;
            vectors_done   <= '0;
        end else begin
            state <= state_n;
            if (state == RD_BLK || state == WR_BLK) b <= '0;
            if ((state == RD_W || state == WR_W) && !spi_busy) b <= b + 10'd1;
            if (state == RD_W && !spi_busy && b < RDN_W) rd[b[RW-1:0]] <= spi_data_out;
            if (state == START) begin
                timer <= '0;
                tmo   <= 1'b0;
                cap   <= '0;
                got   <= '0;
            end
            if (state == RUN) begin
                timer <= timer + 32'd1;
                got   <= got_n;
                for (int c = 0; c < N_OUT; c++)
                    if (uut_valid[c] && !got[c]) cap[8*c +: 8] <= uut_dout[8*c +: 8];
                if (state_n == WR_BLK) tmo <= ~&got_n;
            end
            if (state == NEXT) begin
                if (state_n == START) j <= j + 8'd1;
                else begin
                    j            <= '0;
                    vectors_done <= vectors_done + 16'd1;
                end
            end
            if (state_n == ERROR && state != ERROR) begin
                err_code <= rd_st ? 2'd1 : 2'd2;
                error    <= 1'b1;
            end
            if (state_n == DONE) done <= 1'b1;
            if (state_n == WR_REQ && state != WR_REQ) spi_data_in <= wdat;
            if (state_n inside {RD_BLK, RD_BLK_W, RD_REQ, RD_W})
                spi_block_addr <= CFG_BASE + {16'h0, vectors_done};
            if (state_n inside {WR_BLK, WR_BLK_W, WR_REQ, WR_W})
                spi_block_addr <= RES_BASE + {8'h0, vectors_done, 8'h0} + {24'h0, j};
            spi_rst     <= state_n == SPI_RST;
            spi_r_block <= state_n inside {RD_BLK, RD_BLK_W, RD_REQ, RD_W};
            spi_r_byte  <= state_n == RD_REQ;
            spi_w_block <= state_n inside {WR_BLK, WR_BLK_W, WR_REQ, WR_W};
            spi_w_byte  <= state_n == WR_REQ;
            uut_rst     <= !(state_n inside {START, RUN});
            uut_start   <= state_n == START;
            busy        <= !(state_n inside {IDLE, DONE, ERROR});
        end
    end

endmodule

// File: tb/tb_autotest_multi_ctrl.sv
// tb_autotest_multi_ctrl: directed bench with SD host and UUT models.
// Short TIMEOUT keeps the timeout scenario fast.
module tb_autotest_multi_ctrl;

    localparam logic [31:0] CFG = 32'h00100000;
    localparam logic [31:0] RES = 32'h00200000;
    localparam logic [31:0] SIG = 32'hAABBCCDD;
    localparam logic [31:0] TMO = 32'd200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_busy = 1'b0;
    logic        spi_err = 1'b0;
    logic [7:0]  spi_data_out = 8'h00;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_in;
    logic        spi_rst, spi_r_block, spi_r_byte, spi_w_block, spi_w_byte;
    logic        uut_rst, uut_start;
    logic [31:0] uut_din;
    logic [15:0] uut_dout = 16'h0;
    logic [1:0]  uut_valid = 2'b00;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [15:0] vectors_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    autotest_multi_ctrl #(
        .N_IN_BYTES(4), .N_OUT(2), .TIMEOUT(TMO),
        .CFG_BASE(CFG), .RES_BASE(RES), .SIGNATURE(SIG), .MAX_VECTORS(16'hFFFF)
    ) dut (
        .clk(clk), .rst(rst), .spi_busy(spi_busy), .spi_err(spi_err),
        .spi_data_out(spi_data_out), .spi_block_addr(spi_block_addr),
        .spi_data_in(spi_data_in), .spi_rst(spi_rst), .spi_r_block(spi_r_block),
        .spi_r_byte(spi_r_byte), .spi_w_block(spi_w_block), .spi_w_byte(spi_w_byte),
        .uut_rst(uut_rst), .uut_start(uut_start), .uut_din(uut_din),
        .uut_dout(uut_dout), .uut_valid(uut_valid), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .vectors_done(vectors_done)
    );

    // SD card contents: vector k lives at CFG+k
    logic [31:0] v_sig [4];
    logic [7:0]  v_iter [4];
    logic [31:0] v_din [4];

    function automatic logic [7:0] sd_byte(input logic [31:0] a, input int idx);
        logic [31:0] k;
        k = a - CFG;
        if (k >= 32'd4) return 8'h00;
        if (idx < 4) return v_sig[k[1:0]][8*(3-idx) +: 8];
        if (idx == 4) return v_iter[k[1:0]];
        if (idx < 9) return v_din[k[1:0]][8*(8-idx) +: 8];
        return 8'(idx) ^ 8'h3C;
    endfunction

    // SPI host model: one busy cycle per command edge, logs all blocks
    logic        hclr = 1'b1;
    logic        err_en = 1'b0;
    logic        p_rst = 0, p_rblk = 0, p_rbyte = 0, p_wblk = 0, p_wbyte = 0;
    logic [31:0] cur_r = 0;
    int          ridx = 0, widx = 0, rcnt = 0, wcnt = 0, wslot = 0;
    logic [31:0] raddr [8];
    logic [31:0] waddr [8];
    int          wr_rc [8];
    logic [7:0]  wmem [8][512];

    always @(posedge clk) begin
        p_rst   <= spi_rst;
        p_rblk  <= spi_r_block;
        p_rbyte <= spi_r_byte;
        p_wblk  <= spi_w_block;
        p_wbyte <= spi_w_byte;
        spi_err  <= 1'b0;
        spi_busy <= 1'b0;
        if (hclr) begin
            rcnt <= 0; wcnt <= 0; ridx <= 0; widx <= 0; wslot <= 0;
        end else begin
            if (spi_rst && !p_rst) spi_busy <= 1'b1;
            if (spi_r_block && !p_rblk) begin
                if (rcnt < 8) raddr[rcnt] <= spi_block_addr;
                rcnt <= rcnt + 1;
                cur_r <= spi_block_addr;
                ridx <= 0;
                spi_busy <= 1'b1;
            end
            if (spi_r_byte && !p_rbyte) begin
                spi_data_out <= sd_byte(cur_r, ridx);
                ridx <= ridx + 1;
                spi_busy <= 1'b1;
            end
            if (spi_w_block && !p_wblk) begin
                if (wcnt < 8) begin
                    waddr[wcnt] <= spi_block_addr;
                    wr_rc[wcnt] <= rcnt;
                end
                wslot <= wcnt;
                wcnt <= wcnt + 1;
                widx <= 0;
                spi_busy <= 1'b1;
            end
            if (spi_w_byte && !p_wbyte) begin
                if (wslot < 8 && widx < 512) wmem[wslot][widx] <= spi_data_in;
                widx <= widx + 1;
                spi_busy <= 1'b1;
                if (err_en && widx == 200) spi_err <= 1'b1;
            end
        end
    end

    // UUT model: strobes at fixed RUN-cycle offsets after uut_start
    int         d0 = 0, d1 = 0, dup0 = 0;
    logic [7:0] val0 = 8'h00, val1 = 8'h00;
    int         ucnt = 0;
    int         cnt_n;
    assign cnt_n = uut_start ? 1 : ucnt + 1;

    always @(posedge clk) begin
        ucnt <= cnt_n;
        uut_valid[0] <= (d0 != 0 && cnt_n == d0) || (dup0 != 0 && cnt_n == dup0);
        uut_valid[1] <= (d1 != 0 && cnt_n == d1);
        uut_dout <= {val1, (dup0 != 0 && cnt_n >= dup0) ? 8'hEE : val0};
    end

    task automatic start_run();
        rst = 1'b1;
        hclr = 1'b1;
        repeat (2) @(negedge clk);
        hclr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (uut_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hclr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_rst, spi_r_block, spi_r_byte, spi_w_block, spi_w_byte} !== 5'b0) begin
            failures++;
            $display("FAIL reset_cmds got=%b exp=00000",
                     {spi_rst, spi_r_block, spi_r_byte, spi_w_block, spi_w_byte});
        end
        checks++;
        if ({uut_rst, uut_start} !== 2'b10) begin
            failures++;
            $display("FAIL reset_uut got=%b exp=10", {uut_rst, uut_start});
        end
        checks++;
        if (spi_data_in !== 8'hFF) begin
            failures++;
            $display("FAIL reset_data_in got=%h exp=ff", spi_data_in);
        end
        checks++;
        if ({busy, done, error, err_code} !== 5'b0) begin
            failures++;
            $display("FAIL reset_status got=%b exp=00000", {busy, done, error, err_code});
        end
        checks++;
        if ({spi_block_addr, vectors_done, uut_din} !== 80'h0) begin
            failures++;
            $display("FAIL reset_regs addr=%h vd=%h din=%h exp=0",
                     spi_block_addr, vectors_done, uut_din);
        end
    endtask

    task automatic test_single();
        bit ok;
        int nz;
        logic [7:0] e [16];
        v_sig[0] = SIG; v_iter[0] = 8'd1; v_din[0] = 32'h01020304; v_sig[1] = 32'h0;
        d0 = 100; d1 = 100; dup0 = 0; val0 = 8'hA5; val1 = 8'h5A; err_en = 1'b0;
        e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h01, 8'h02, 8'h03,
              8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'hA5, 8'h5A};
        start_run();
        wait_start(4000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_start got=timeout exp=uut_start");
        end
        checks++;
        if ({uut_din, uut_rst} !== {32'h01020304, 1'b0}) begin
            failures++;
            $display("FAIL single_din got=%h/%b exp=01020304/0", uut_din, uut_rst);
        end
        @(negedge clk);
        checks++;
        if ({uut_start, uut_rst} !== 2'b00) begin
            failures++;
            $display("FAIL single_pulse got=%b exp=00", {uut_start, uut_rst});
        end
        wait_end(6000, ok);
        checks++;
        if (!ok || {done, error, busy, uut_rst} !== 4'b1001) begin
            failures++;
            $display("FAIL single_end got=%b exp=1001", {done, error, busy, uut_rst});
        end
        checks++;
        if (vectors_done !== 16'd1 || wcnt !== 1 || rcnt !== 2) begin
            failures++;
            $display("FAIL single_counts got=vd%0d w%0d r%0d exp=vd1 w1 r2",
                     vectors_done, wcnt, rcnt);
        end
        checks++;
        if (waddr[0] !== RES || raddr[1] !== CFG + 32'd1 || widx !== 512) begin
            failures++;
            $display("FAIL single_addr got=%h/%h/%0d exp=%h/%h/512",
                     waddr[0], raddr[1], widx, RES, CFG + 32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (wmem[0][i] !== e[i]) begin
                failures++;
                $display("FAIL single_byte%0d got=%h exp=%h", i, wmem[0][i], e[i]);
            end
        end
        nz = 0;
        for (int i = 16; i < 512; i++) if (wmem[0][i] !== 8'h00) nz++;
        checks++;
        if (nz != 0) begin
            failures++;
            $display("FAIL single_tail got=%0d nonzero exp=0", nz);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [7:0] e [16];
        v_sig[0] = SIG; v_iter[0] = 8'd1; v_din[0] = 32'hDEADBEEF; v_sig[1] = 32'h0;
        d0 = 10; dup0 = 20; d1 = 0; val0 = 8'h11; val1 = 8'h99;
        e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'hDE, 8'hAD, 8'hBE,
              8'hEF, 8'h03, 8'h00, 8'h00, 8'h00, 8'hC8, 8'h11, 8'h00};
        start_run();
        wait_end(8000, ok);
        checks++;
        if (!ok || {done, error} !== 2'b10 || wcnt !== 1) begin
            failures++;
            $display("FAIL tmo_end got=%b w%0d exp=10 w1", {done, error}, wcnt);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (wmem[0][i] !== e[i]) begin
                failures++;
                $display("FAIL tmo_byte%0d got=%h exp=%h", i, wmem[0][i], e[i]);
            end
        end
    endtask

    task automatic test_iter();
        bit ok;
        logic [7:0] e [16];
        v_sig[0] = SIG; v_iter[0] = 8'd3; v_din[0] = 32'h0A0B0C0D;
        v_sig[1] = SIG; v_iter[1] = 8'd0; v_din[1] = 32'h11223344;
        v_sig[2] = 32'h0;
        d0 = 5; d1 = 5; dup0 = 0; val0 = 8'hA5; val1 = 8'h5A;
        start_run();
        wait_end(20000, ok);
        checks++;
        if (!ok || {done, error, busy} !== 3'b100 || vectors_done !== 16'd2) begin
            failures++;
            $display("FAIL iter_end got=%b vd%0d exp=100 vd2", {done, error, busy}, vectors_done);
        end
        checks++;
        if (wcnt !== 4 || rcnt !== 3) begin
            failures++;
            $display("FAIL iter_counts got=w%0d r%0d exp=w4 r3", wcnt, rcnt);
        end
        checks++;
        if (raddr[1] !== CFG + 32'd1 || raddr[2] !== CFG + 32'd2) begin
            failures++;
            $display("FAIL iter_raddr got=%h/%h exp=%h/%h",
                     raddr[1], raddr[2], CFG + 32'd1, CFG + 32'd2);
        end
        for (int s = 0; s < 4; s++) begin
            if (s < 3)
                e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'(s), 8'h0A, 8'h0B, 8'h0C,
                      8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'hA5, 8'h5A};
            else
                e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h11, 8'h22, 8'h33,
                      8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'hA5, 8'h5A};
            checks++;
            if (waddr[s] !== ((s < 3) ? RES + 32'(s) : RES + 32'h100)) begin
                failures++;
                $display("FAIL iter_waddr%0d got=%h", s, waddr[s]);
            end
            checks++;
            if (wr_rc[s] !== ((s < 3) ? 1 : 2)) begin
                failures++;
                $display("FAIL iter_reads_before_w%0d got=%0d exp=%0d",
                         s, wr_rc[s], (s < 3) ? 1 : 2);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wmem[s][i] !== e[i]) begin
                    failures++;
                    $display("FAIL iter_w%0d_byte%0d got=%h exp=%h", s, i, wmem[s][i], e[i]);
                end
            end
        end
    endtask

    task automatic test_error();
        bit ok;
        int act;
        v_sig[0] = SIG; v_iter[0] = 8'd1; v_din[0] = 32'h01020304; v_sig[1] = 32'h0;
        d0 = 5; d1 = 5; dup0 = 0; err_en = 1'b1;
        start_run();
        wait_end(6000, ok);
        checks++;
        if (!ok || {error, done, busy, uut_rst} !== 4'b1001) begin
            failures++;
            $display("FAIL err_state got=%b exp=1001", {error, done, busy, uut_rst});
        end
        checks++;
        if (err_code !== 2'd2 || widx !== 201) begin
            failures++;
            $display("FAIL err_code got=%0d bytes=%0d exp=2 bytes=201", err_code, widx);
        end
        act = 0;
        repeat (40) begin
            @(negedge clk);
            if (|{spi_rst, spi_r_block, spi_r_byte, spi_w_block, spi_w_byte}) act++;
        end
        checks++;
        if (act != 0 || error !== 1'b1) begin
            failures++;
            $display("FAIL err_quiet got=%0d active cycles exp=0", act);
        end
        err_en = 1'b0;
    endtask

    task automatic test_rst_run();
        bit ok;
        logic [7:0] e [16];
        v_sig[0] = SIG; v_iter[0] = 8'd1; v_din[0] = 32'h55667788; v_sig[1] = 32'h0;
        d0 = 0; d1 = 0; dup0 = 0; val0 = 8'h33; val1 = 8'h77;
        e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h55, 8'h66, 8'h77,
              8'h88, 8'h03, 8'h00, 8'h00, 8'h00, 8'hC8, 8'h00, 8'h77};
        start_run();
        wait_start(4000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstrun_start got=timeout exp=uut_start");
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        hclr = 1'b1;
        @(negedge clk);
        checks++;
        if ({uut_rst, uut_start, busy} !== 3'b100 ||
            {spi_rst, spi_r_block, spi_r_byte, spi_w_block, spi_w_byte} !== 5'b0) begin
            failures++;
            $display("FAIL rstrun_idle got=%b exp=100", {uut_rst, uut_start, busy});
        end
        d1 = 7;
        hclr = 1'b0;
        rst = 1'b0;
        wait_end(8000, ok);
        checks++;
        if (!ok || raddr[0] !== CFG || wcnt !== 1 || vectors_done !== 16'd1) begin
            failures++;
            $display("FAIL rstrun_restart got=%h w%0d vd%0d exp=%h w1 vd1",
                     raddr[0], wcnt, vectors_done, CFG);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (wmem[0][i] !== e[i]) begin
                failures++;
                $display("FAIL rstrun_byte%0d got=%h exp=%h", i, wmem[0][i], e[i]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            v_sig[k] = 32'h0;
            v_iter[k] = 8'h0;
            v_din[k] = 32'h0;
        end
        test_reset();
        test_single();
        test_timeout();
        test_iter();
        test_error();
        test_rst_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
